// File: rtl/ota_bitstream_decimator_if.sv
// Bus between the OTA bitstream decimator and its controller/readout logic.
interface ota_bitstream_decimator_if #(
  parameter int unsigned WIN_LOG2 = 8
);
  logic                ena;
  logic                clr;
  logic                bit_in;
  logic [WIN_LOG2:0]   sample_out;
  logic                sample_valid;
  logic                stuck_hi;
  logic                stuck_lo;
  logic                busy;

  modport master (
    output ena, clr, bit_in,
    input  sample_out, sample_valid, stuck_hi, stuck_lo, busy
  );

  modport slave (
    input  ena, clr, bit_in,
    output sample_out, sample_valid, stuck_hi, stuck_lo, busy
  );
endinterface

// File: rtl/ota_bitstream_decimator.sv
// Synchronizes the asynchronous OTA comparator bitstream and decimates it into
// ones-counts over fixed 2^WIN_LOG2-cycle windows, with stuck-high/low flags.
module ota_bitstream_decimator #(
  parameter int unsigned WIN_LOG2    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ota_bitstream_decimator_if.slave bus
);

  localparam int unsigned SW = WIN_LOG2 + 1;
  localparam int unsigned FW = (SYNC_STAGES > 2) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [SW-1:0] FULL_CNT = SW'(1) << WIN_LOG2;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(SYNC_STAGES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          flush_q, flush_d;
  logic [WIN_LOG2-1:0]    win_q, win_d;
  logic [WIN_LOG2-1:0]    acc_q, acc_d;
  logic [SW-1:0]          sample_q;
  logic                   valid_q, stuck_hi_q, stuck_lo_q, busy_q;
  logic                   bit_s_c;
  logic                   win_end_c;
  logic [SW-1:0]          sum_c;

  assign bit_s_c = sync_q[SYNC_STAGES-1];
  // acc never exceeds 2^WIN_LOG2-1, so the final sum always fits SW bits
  assign sum_c   = SW'(acc_q) + SW'(bit_s_c);

  // Next-state, window counter and accumulator update
  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    win_d     = win_q;
    acc_d     = acc_q;
    win_end_c = 1'b0;
    if (bus.clr) begin
      state_d = IDLE;
      flush_d = '0;
      win_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ena) begin
            state_d = FLUSH;
            flush_d = '0;
          end
        end
        FLUSH: begin
          if (!bus.ena) begin
            state_d = IDLE;
          end else if (flush_q == FLUSH_LAST) begin
            state_d = RUN;
            win_d   = '0;
            acc_d   = '0;
          end else begin
            flush_d = flush_q + 1'b1;
          end
        end
        RUN, PAUSE: begin
          // The resuming edge out of PAUSE counts; the pausing edge does not
          if (!bus.ena) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            win_d   = win_q + 1'b1;
            if (win_q == '1) begin
              win_end_c = 1'b1;
              acc_d     = '0;
            end else begin
              acc_d = acc_q + WIN_LOG2'(bit_s_c);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      flush_q    <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.bit_in};
      flush_q <= flush_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      valid_q <= win_end_c;
      busy_q  <= (state_d == FLUSH) || (state_d == RUN);
      if (win_end_c) begin
        sample_q   <= sum_c;
        stuck_hi_q <= (sum_c == FULL_CNT);
        stuck_lo_q <= (sum_c == '0);
      end
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.stuck_hi     = stuck_hi_q;
  assign bus.stuck_lo     = stuck_lo_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Scoreboard bench for ota_bitstream_decimator with WIN_LOG2=4, SYNC_STAGES=2.
module tb_ota_bitstream_decimator;

  localparam int unsigned W  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned SW = W + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ota_bitstream_decimator_if #(.WIN_LOG2(W)) dif();

  ota_bitstream_decimator #(.WIN_LOG2(W), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  typedef struct {
    int            cyc;
    logic [SW-1:0] val;
    logic          hi;
    logic          lo;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;
  logic toggle_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the next scoreboard entry, including its cycle
  always @(negedge clk) begin
    exp_t e;
    if (dif.sample_valid === 1'b1) begin
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL strobe_consecutive cyc=%0d got two strobes in a row, required isolated", cyc);
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d sample_out=%0d, required no strobe", cyc, dif.sample_out);
      end else begin
        e = sbq.pop_front();
        if (cyc !== e.cyc || dif.sample_out !== e.val || dif.stuck_hi !== e.hi || dif.stuck_lo !== e.lo) begin
          errors++;
          $display("FAIL strobe got cyc=%0d out=%0d hi=%b lo=%b, required cyc=%0d out=%0d hi=%b lo=%b",
                   cyc, dif.sample_out, dif.stuck_hi, dif.stuck_lo, e.cyc, e.val, e.hi, e.lo);
        end
      end
    end
    prev_valid = (dif.sample_valid === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (toggle_en) dif.bit_in = ~dif.bit_in;
    end
  endtask

  task automatic push(input int c, input int v);
    exp_t e;
    e.cyc = c;
    e.val = SW'(v);
    e.hi  = (v == (1 << W));
    e.lo  = (v == 0);
    sbq.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int b = budget;
    while (sbq.size() != 0 && b > 0) begin
      tick(1);
      b--;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout %0d strobes outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_outputs(input string name, input int out, input logic v,
                               input logic hi, input logic lo, input logic bsy);
    checks++;
    if (dif.sample_out !== SW'(out) || dif.sample_valid !== v || dif.stuck_hi !== hi ||
        dif.stuck_lo !== lo || dif.busy !== bsy) begin
      errors++;
      $display("FAIL %s got out=%0d v=%b hi=%b lo=%b busy=%b, required out=%0d v=%b hi=%b lo=%b busy=%b",
               name, dif.sample_out, dif.sample_valid, dif.stuck_hi, dif.stuck_lo, dif.busy,
               out, v, hi, lo, bsy);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    dif.ena   = 1'b0;
    dif.clr   = 1'b0;
    toggle_en = 1'b1;
    tick(n);
    check_outputs("reset_state", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    toggle_en  = 1'b0;
    dif.bit_in = 1'b0;
    rst_n      = 1'b1;
    sbq.delete();
  endtask

  task automatic test_reset();
    do_reset(3);
    tick(2);
    check_outputs("idle_after_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_const_high();
    int c0;
    do_reset(2);
    dif.bit_in = 1'b1;
    dif.ena    = 1'b1;
    c0 = cyc;
    push(c0 + 19, 16);
    push(c0 + 35, 16);
    push(c0 + 51, 16);
    tick(1);
    check_outputs("flush_busy", 0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain(60);
    dif.ena = 1'b0;
  endtask

  task automatic test_alternating();
    int c0;
    do_reset(2);
    dif.bit_in = 1'b1;
    toggle_en  = 1'b1;
    dif.ena    = 1'b1;
    c0 = cyc;
    push(c0 + 19, 8);
    push(c0 + 35, 8);
    push(c0 + 51, 8);
    wait_drain(60);
    toggle_en = 1'b0;
    dif.ena   = 1'b0;
  endtask

  task automatic test_pause();
    int c0;
    do_reset(2);
    dif.bit_in = 1'b1;
    dif.ena    = 1'b1;
    c0 = cyc;
    push(c0 + 24, 16);
    tick(8);
    dif.ena = 1'b0;
    tick(5);
    check_outputs("paused_not_busy", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    dif.ena = 1'b1;
    wait_drain(30);
    dif.ena = 1'b0;
  endtask

  task automatic test_clr();
    int c0;
    int e;
    do_reset(2);
    dif.bit_in = 1'b1;
    dif.ena    = 1'b1;
    c0 = cyc;
    push(c0 + 19, 16);
    tick(19);
    wait_drain(5);
    tick(10);
    dif.clr    = 1'b1;
    dif.bit_in = 1'b0;
    tick(1);
    dif.clr = 1'b0;
    e = cyc;
    check_outputs("clr_keeps_sample", 16, 1'b0, 1'b1, 1'b0, 1'b0);
    push(e + 19, 0);
    wait_drain(30);
    dif.ena = 1'b0;
  endtask

  task automatic test_reset_mid_window();
    int c0;
    do_reset(2);
    dif.bit_in = 1'b1;
    dif.ena    = 1'b1;
    tick(10);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_outputs("mid_window_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    c0 = cyc;
    push(c0 + 19, 16);
    push(c0 + 35, 16);
    push(c0 + 51, 16);
    wait_drain(60);
    dif.ena = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    dif.ena    = 1'b0;
    dif.clr    = 1'b0;
    dif.bit_in = 1'b0;
    test_reset();
    test_const_high();
    test_alternating();
    test_pause();
    test_clr();
    test_reset_mid_window();
    do_reset(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
